// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver.
//
// Contents:
//   MIN_BIT_PERIOD, MIN_DATA_SIZE, MAX_DATA_SIZE  configuration limits
//   rx_timer_state_t                              bit-timer FSM encoding
//   clamp_data_size()                             folds data_size into 5..8
package uart_rx_pkg;

  localparam int MIN_BIT_PERIOD = 4;
  localparam int MIN_DATA_SIZE  = 5;
  localparam int MAX_DATA_SIZE  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } rx_timer_state_t;

  // 0..4 -> 5, 9..15 -> 8, anything else passes through.
  function automatic logic [3:0] clamp_data_size(input logic [3:0] ds);
    logic [3:0] result;
    result = ds;
    if (ds < 4'(MIN_DATA_SIZE)) begin
      result = 4'(MIN_DATA_SIZE);
    end else if (ds > 4'(MAX_DATA_SIZE)) begin
      result = 4'(MAX_DATA_SIZE);
    end
    return result;
  endfunction

endpackage

// File: rtl/rx_bit_timer_flex_counter.sv
// flex_counter: generic up-counter with synchronous clear and programmable
// rollover value.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset, count -> 0
//   clear          synchronous clear, count -> 0 (beats count_enable)
//   count_enable   advance the count this cycle
//   rollover_val   last value before wrapping; the count wraps to 1
//   count_out      current count
//   rollover_flag  high while count_out equals rollover_val
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      if (count_q == rollover_val) begin
        count_d = WIDTH'(1);
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out     = count_q;
  // Decoded from the registered count, so it is a clean state output.
  assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit-timing stage of the UART receiver.
//
// Generates mid-bit sample strobes for the shift register while the control
// FSM holds enable_timer high. Bit period and data size are snapshotted on the
// first enabled cycle (cycle 0) so config writes cannot disturb a frame.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   enable_timer   from control FSM, high for the whole data phase
//   bit_period     clocks per bit (values below 4 behave as 4)
//   data_size      data bits per frame (clamped into 5..8)
//   shift_strobe   1-cycle pulse: sample serial_in now
//   packet_done    1-cycle pulse coincident with the final strobe
//   bit_index      strobes issued so far this frame
//   busy           high while in COUNT
//   parity_strobe  present only with RX_TIMER_PARITY_EN defined; pulses
//                  with the strobe that samples the parity bit
//
// Build option: RX_TIMER_PARITY_EN adds a parity bit to the frame
// (N = ds + 2 strobes instead of ds + 1) and the parity_strobe port.
module rx_bit_timer
  import uart_rx_pkg::*;
#(
  parameter int BP_WIDTH  = 14,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_timer,
  input  logic [BP_WIDTH-1:0]  bit_period,
  input  logic [3:0]           data_size,
  output logic                 shift_strobe,
  output logic                 packet_done,
  output logic [CNT_WIDTH-1:0] bit_index,
`ifdef RX_TIMER_PARITY_EN
  output logic                 parity_strobe,
`endif
  output logic                 busy
);

  // One extra bit so bp + (bp >> 1) always fits.
  localparam int PH_WIDTH = BP_WIDTH + 1;

  rx_timer_state_t      state_q, state_d;
  logic [BP_WIDTH-1:0]  bp_q, bp_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [3:0]           ds_clamped;
  logic                 cycle0;

  logic [PH_WIDTH-1:0]  phase_cnt;
  logic [PH_WIDTH-1:0]  phase_rollover;
  logic [PH_WIDTH-1:0]  first_rollover;
  logic                 phase_flag;
  logic                 phase_clear;

  logic [CNT_WIDTH-1:0] bit_cnt;
  logic                 bit_flag;
  logic                 bit_clear;
  logic                 bit_advance;

  logic                 in_count;
  logic                 last_strobe;

  assign in_count   = (state_q == COUNT);
  assign cycle0     = (state_q == IDLE) && enable_timer;
  assign ds_clamped = clamp_data_size(data_size);

  // Config snapshot: loaded only in cycle 0, held for the rest of the frame.
  always_comb begin
    bp_d = bp_q;
    n_d  = n_q;
    if (cycle0) begin
      if (bit_period < BP_WIDTH'(MIN_BIT_PERIOD)) begin
        bp_d = BP_WIDTH'(MIN_BIT_PERIOD);
      end else begin
        bp_d = bit_period;
      end
`ifdef RX_TIMER_PARITY_EN
      n_d = CNT_WIDTH'(ds_clamped) + CNT_WIDTH'(2);
`else
      n_d = CNT_WIDTH'(ds_clamped) + CNT_WIDTH'(1);
`endif
    end
  end

  // The phase counter reads phase k-1 in frame cycle k (it is cleared at the
  // cycle-0 edge), and after a wrap it restarts at 1. So the first strobe,
  // due at cycle bp + bp/2, needs a rollover one below that; every later
  // strobe is a full wrap of 1..bp.
  assign first_rollover = {1'b0, bp_q} + PH_WIDTH'(bp_q >> 1) - PH_WIDTH'(1);
  assign phase_rollover = (bit_cnt == '0) ? first_rollover : {1'b0, bp_q};
  assign phase_clear    = !in_count || !enable_timer;

  flex_counter #(
    .WIDTH (PH_WIDTH)
  ) u_phase_counter (
    .clk           (clk),
    .rst           (rst),
    .clear         (phase_clear),
    .count_enable  (1'b1),
    .rollover_val  (phase_rollover),
    .count_out     (phase_cnt),
    .rollover_flag (phase_flag)
  );

  // The bit counter clears in cycle 0 and on any disabled cycle; the flag
  // (count == N) blocks any further advance so it saturates at N.
  assign bit_clear   = (state_q == IDLE) || !enable_timer;
  assign bit_advance = shift_strobe && !bit_flag;

  flex_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_bit_counter (
    .clk           (clk),
    .rst           (rst),
    .clear         (bit_clear),
    .count_enable  (bit_advance),
    .rollover_val  (n_q),
    .count_out     (bit_cnt),
    .rollover_flag (bit_flag)
  );

  // Strobes are decoded from registered state; only enable_timer reaches
  // the pulse outputs combinationally, so a dropped enable kills them at once.
  assign shift_strobe = in_count && phase_flag && enable_timer;
  assign last_strobe  = (bit_cnt == n_q - CNT_WIDTH'(1));
  assign packet_done  = shift_strobe && last_strobe;

`ifdef RX_TIMER_PARITY_EN
  // Parity is the strobe just before the stop bit (pre-increment index == ds).
  assign parity_strobe = shift_strobe && (bit_cnt == n_q - CNT_WIDTH'(2));
`endif

  assign bit_index = bit_cnt;
  assign busy      = in_count;

  always_comb begin
    state_d = state_q;
    if (!enable_timer) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = COUNT;
        COUNT:   if (packet_done) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bp_q    <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      bp_q    <= bp_d;
      n_q     <= n_d;
    end
  end

endmodule
